serial_receiver: RTL

Serial-to-parallel receiver that sits directly downstream of the 7-bit serial shifter. It samples the shifter's serial output bit stream LSB-first, discards the leading dummy 0 bit, reassembles the word, and presents it with a one-cycle valid pulse. It also drives the shifter's `done` input so that the shifter only shifts while a word is in flight.

---
 rtl/serial_receiver.sv | 93 +++++++++
 1 files changed

// File: rtl/serial_receiver.sv
// serial_receiver: rebuilds LSB-first words from the serial shifter stream.
// Ports: clk, rst (sync high), start, sin -> done, data, valid, busy, abort.
module serial_receiver #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  output logic             done,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             abort
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    RECV,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] data_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             abort_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      data  <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      data  <= data_n;
      abort <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    data_n  = data;
    abort_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SKIP;
      end
      SKIP: begin
        // first sample after load is the dummy 0
        cnt_n = '0;
        if (start) abort_n = 1'b1;
        else       state_n = RECV;
      end
      RECV: begin
        if (start) begin
          // restart: drop partial word
          state_n = SKIP;
          cnt_n   = '0;
          abort_n = 1'b1;
        end else begin
          shreg_n = {sin, shreg[WIDTH-1:1]};
          if (cnt == LAST) begin
            // hold cnt at LAST so it never wraps
            data_n  = {sin, shreg[WIDTH-1:1]};
            state_n = DONE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_n = start ? SKIP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign valid = (state == DONE);
  assign busy  = (state == SKIP) || (state == RECV);
  assign done  = ~busy;

endmodule
